fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of an async FIFO among NUM_REQ requesters on the write-clock side.
//  - Round-robin arbitration.
//  - Packet/burst locking: a grant is held until the requester's last beat or MAX_BURST beats.
//  - Drives the FIFO wr_en/din and honours its full flag.
//  - Sits between the producer engines and the FIFO write interface.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  16  beat width; equals the FIFO data_width
//  MAX_BURST   8   max beats per grant before forced re-arbitration (>=1)
// PORTS
//  clk         in   1                   write-domain clock (same clock as the FIFO wr_clk)
//  rst         in   1                   synchronous, active-high reset
//  req_valid   in   NUM_REQ             per-requester beat valid
//  req_last    in   NUM_REQ             per-requester last beat of packet (qualified by valid)
//  req_data    in   NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready   out  NUM_REQ             beat accepted when req_valid[i] & req_ready[i]
//  fifo_full   in   1                   FIFO full flag
//  fifo_wr_en  out  1                   FIFO write enable
//  fifo_din    out  DATA_WIDTH          FIFO write data
//  grant_id    out  clog2(NUM_REQ)      currently granted requester (registered)
//  busy        out  1                   1 while in GRANT state
// BEHAVIOUR
//  States:
//  - IDLE: if any req_valid, pick a winner, register it in grant_id, load beat_cnt=0, go to GRANT.
//    Otherwise stay in IDLE.
//  - GRANT: serve requester g = grant_id.
//  Round-robin: search starts at rr_ptr and wraps modulo NUM_REQ. First valid requester wins.
//  Transfer in GRANT (combinational):
//  - req_ready[g] = ~fifo_full.
//  - req_ready[i != g] = 0.
//  - fifo_wr_en = req_valid[g] & ~fifo_full.
//  - fifo_din = req_data[g] when granted; 0 when not in GRANT.
//  Accepted beat (fifo_wr_en=1) increments beat_cnt (width clog2(MAX_BURST+1)).
//  GRANT -> IDLE when an accepted beat has req_last[g]=1 OR beat_cnt == MAX_BURST-1.
//  - On that transition rr_ptr <= (g+1) mod NUM_REQ.
//  - IDLE always lasts >=1 cycle, so there is one bubble between grants.
//  Full: while fifo_full=1 there is no write, req_ready is all 0, beat_cnt holds, and the grant holds.
//  req_valid[g] low in GRANT: the grant holds (packet lock), with no write and no count.
//  Requesters must not drop a packet mid-stream.
//  Other requesters never see ready while g is locked.
//  Simultaneous last and cap on the same beat: a single exit to IDLE.
//  Reset (any cycle, including mid-burst):
//  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
//  - busy=0, fifo_wr_en=0, fifo_din=0, req_ready=0 in the following cycle.
//  - An in-flight packet is abandoned; no partial write occurs in the reset cycle.
//  Latency: first beat of a new grant is written 1 cycle after arbitration (IDLE -> GRANT).
//  Throughput inside a grant is 1 beat/cycle.
// STRUCTURE
//  fifo_arb_pkg: state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1), width helper for clog2(NUM_REQ).
//  Sub-module rr_pick: combinational round-robin priority picker.
//  - Inputs: req vector, rr_ptr.
//  - Outputs: winner index, any_req.
//  Top holds the FSM, beat counter, rr_ptr and the data mux.
// TESTING
//  1 Reset mid-burst: assert rst during a 5-beat burst of req1.
//    -> next cycle busy=0, fifo_wr_en=0, grant_id=0; rr_ptr=0 so req0 wins next.
//  2 Round-robin: all 4 requesters send 1-beat packets (last=1) continuously.
//    -> grant order 0,1,2,3,0; each write is followed by 1 IDLE bubble.
//  3 Burst cap: req2 streams 20 beats, last=0, MAX_BURST=8.
//    -> exactly 8 writes, then IDLE; req2 regains the grant only after the other valid requesters.
//  4 Full back-pressure: fifo_full=1 for cycles 3-6 of a req0 burst.
//    -> wr_en=0 and ready=0 on those cycles; no beat lost or duplicated; data order D0..Dn preserved.
//  5 Valid gap: req3 granted, drops valid for 3 cycles while req0 is valid.
//    -> grant stays 3, req_ready[0]=0, no writes; resumes when req3 is valid again.
//  6 Last on the cap beat: req1 sends 8 beats with last on beat 8.
//    -> single exit, rr_ptr=2, no extra idle cycle beyond the one bubble.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the async-FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Index width for n requesters; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    int idx;

    // Scan from the farthest offset down so the closest request to rr_ptr is written last.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) winner = IW'(idx);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one async-FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8,
    localparam int IW = idx_width(NUM_REQ),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic            granted;
    logic            burst_end;
    logic [IW-1:0]   next_ptr;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Reset masks the write path immediately so an abandoned burst never leaks a beat.
    assign granted = (state == ST_GRANT) && !rst;

    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (granted) begin
            req_ready[grant_id] = ~fifo_full;
            fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
            fifo_din            = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign burst_end = fifo_wr_en & (req_last[grant_id] | (beat_cnt == CW'(MAX_BURST - 1)));
    assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = (state == ST_GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Last beat and cap on the same beat collapse into one exit.
                    if (burst_end) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: a transaction-level requester/arbiter model feeds expectation queues; a monitor compares.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic [IW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed {
        logic busy; logic [IW-1:0] gid; logic [N-1:0] ready; logic wr; logic [DW-1:0] din;
    } cyc_t;
    typedef struct packed { logic [IW-1:0] gid; logic [DW-1:0] din; } wr_t;

    beat_t pend[N][$];
    cyc_t  cyc_q[$];
    wr_t   wr_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: who owns the port, beats taken in this grant, where the next search starts.
    int    m_owner = -1;
    int    m_cnt   = 0;
    int    m_ptr   = 0;
    int    m_gid   = 0;

    int           vprob = 100;
    int           fprob = 0;
    logic         force_full = 1'b0;
    logic [N-1:0] gap_mask = '0;
    int           seq [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.data = (DW'(r) << 12) | DW'(seq[r] & 12'hfff);
            bt.last = (b == len - 1);
            seq[r]++;
            pend[r].push_back(bt);
        end
    endtask

    task automatic step(input bit do_rst);
        logic [N-1:0]    v, l;
        logic [N*DW-1:0] d;
        logic            f;
        cyc_t            e;
        wr_t             w;
        int              g;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v[i] = (pend[i].size() > 0) && !gap_mask[i] && ($urandom_range(99) < vprob);
            d[i*DW +: DW] = (pend[i].size() > 0) ? pend[i][0].data : DW'($urandom);
            l[i] = (pend[i].size() > 0) ? pend[i][0].last : 1'b0;
        end
        f = force_full || ($urandom_range(99) < fprob);
        rst = do_rst; req_valid = v; req_last = l; req_data = d; fifo_full = f;

        e = '0;
        e.busy = (m_owner >= 0);
        e.gid  = IW'(m_gid);
        if (do_rst) begin
            m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) pend[i].delete();
        end else if (m_owner < 0) begin
            for (int k = N - 1; k >= 0; k--)
                if (v[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin m_gid = m_owner; m_cnt = 0; end
        end else begin
            g = m_owner;
            e.ready[g] = !f;
            e.din = d[g*DW +: DW];
            if (v[g] && !f) begin
                e.wr = 1'b1;
                w.gid = IW'(g); w.din = d[g*DW +: DW];
                wr_q.push_back(w);
                void'(pend[g].pop_front());
                m_cnt++;
                if (l[g] || m_cnt == MB) begin
                    m_ptr = (g + 1) % N; m_owner = -1; m_cnt = 0;
                end
            end
        end
        cyc_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    initial begin : monitor
        cyc_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("busy",       64'(busy),       64'(e.busy));
                chk("grant_id",   64'(grant_id),   64'(e.gid));
                chk("req_ready",  64'(req_ready),  64'(e.ready));
                chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e.wr));
                chk("fifo_din",   64'(fifo_din),   64'(e.din));
                if (fifo_wr_en === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 64'(fifo_din), 64'hdead);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_data", 64'(fifo_din), 64'(w.din));
                        chk("write_src",  64'(grant_id), 64'(w.gid));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        bit pending;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        step(1'b1); step(1'b1);

        // Reset mid-burst, then req0 must win from a cleared pointer.
        add_pkt(1, 5);
        run(3);
        step(1'b1);
        add_pkt(1, 1); add_pkt(0, 1);
        run(6);

        // Round-robin on single-beat packets.
        for (int r = 0; r < N; r++) begin add_pkt(r, 1); add_pkt(r, 1); end
        run(20);

        // Burst cap on a long packet with competitors waiting.
        add_pkt(2, 20); add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2);
        run(45);

        // Full back-pressure mid-burst.
        add_pkt(0, 8);
        for (int c = 0; c < 14; c++) begin
            force_full = (c >= 3 && c <= 6);
            step(1'b0);
        end
        force_full = 1'b0;

        // Valid gap on the locked requester while another waits.
        add_pkt(3, 4);
        run(2);
        gap_mask[3] = 1'b1;
        add_pkt(0, 1);
        run(3);
        gap_mask = '0;
        run(10);

        // Last coincident with the cap beat.
        add_pkt(1, 8); add_pkt(2, 1);
        run(14);

        // Randomized traffic with gaps and back-pressure.
        vprob = 70; fprob = 20;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N; r++)
                if (pend[r].size() < 3 && $urandom_range(3) == 0)
                    add_pkt(r, 1 + $urandom_range(11));
            if (c == 200) step(1'b1); else step(1'b0);
        end

        // Drain everything that is still queued.
        vprob = 100; fprob = 0;
        guard = 0;
        pending = 1'b1;
        while (pending && guard < 2000) begin
            step(1'b0);
            guard++;
            pending = 1'b0;
            for (int r = 0; r < N; r++) if (pend[r].size() > 0) pending = 1'b1;
        end
        chk("drain_timeout", 64'(pending), 64'd0);
        run(3);
        #5;
        chk("cyc_q_empty", 64'(cyc_q.size()), 64'd0);
        chk("wr_q_empty",  64'(wr_q.size()),  64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
